// File: rtl/centroid_div_scheduler_if.sv
// Bundle between the per-cluster centroid accumulators, the divider scheduler
// and the shared pipelined divider.
//   req/sum_bus/count_bus : requester operands (dividend cluster i at [20*i+:20],
//                           divisor cluster i at [12*i+:12]); req held until ack
//   ack                   : one-hot capture pulse back to the requester
//   res_valid/res_id/res_quotient : tagged result pulse
//   busy                  : a division is in flight
//   div_*                 : divider control/operands out, quotient back in
// slave  = scheduler side, master = accumulator + divider side.
interface centroid_div_scheduler_if #(
   parameter int NUM_CLUSTERS = 4,
   parameter int ID_W         = 2
);
   logic [NUM_CLUSTERS-1:0]    req;
   logic [NUM_CLUSTERS*20-1:0] sum_bus;
   logic [NUM_CLUSTERS*12-1:0] count_bus;
   logic [NUM_CLUSTERS-1:0]    ack;
   logic                       res_valid;
   logic [ID_W-1:0]            res_id;
   logic [19:0]                res_quotient;
   logic                       busy;
   logic                       div_ce;
   logic                       div_sclr;
   logic [19:0]                div_dividend;
   logic [11:0]                div_divisor;
   logic [19:0]                div_quotient;

   modport slave (
      input  req, sum_bus, count_bus, div_quotient,
      output ack, res_valid, res_id, res_quotient, busy,
             div_ce, div_sclr, div_dividend, div_divisor
   );

   modport master (
      output req, sum_bus, count_bus, div_quotient,
      input  ack, res_valid, res_id, res_quotient, busy,
             div_ce, div_sclr, div_dividend, div_divisor
   );
endinterface

// File: rtl/centroid_div_scheduler.sv
// Shares one pipelined 20/12-bit divider among NUM_CLUSTERS centroid-update
// requesters. Round-robin arbitration picks one requester, latches its
// operands, holds the divider clock-enable for DIV_LATENCY+1 cycles and then
// returns the quotient tagged with the requester id. A zero member count is
// answered immediately with quotient 0 without touching the divider.
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous active-low reset
//   io_bus   centroid_div_scheduler_if.slave (requester + divider signals)
// All outputs are registered.
module centroid_div_scheduler #(
   parameter int NUM_CLUSTERS = 4,
   parameter int ID_W         = 2,
   parameter int DIV_LATENCY  = 20
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   centroid_div_scheduler_if.slave    io_bus
);

   localparam int               CNT_W    = $clog2(DIV_LATENCY + 2);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                  r_state, w_state_nxt;
   logic [NUM_CLUSTERS-1:0] r_ack, w_ack_nxt;
   logic                    r_res_valid, w_res_valid_nxt;
   logic [ID_W-1:0]         r_res_id, w_res_id_nxt;
   logic [19:0]             r_res_q, w_res_q_nxt;
   logic                    r_busy, w_busy_nxt;
   logic                    r_div_ce, w_div_ce_nxt;
   logic                    r_div_sclr;
   logic [19:0]             r_dividend, w_dividend_nxt;
   logic [11:0]             r_divisor, w_divisor_nxt;
   logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
   logic [ID_W-1:0]         r_rr_ptr, w_rr_ptr_nxt;

   // arbitration result
   logic                    w_found;
   logic [ID_W-1:0]         w_gnt;
   logic [NUM_CLUSTERS-1:0] w_gnt_oh;
   logic [19:0]             w_sum;
   logic [11:0]             w_cnt_op;

   // Round-robin: first requester above rr_ptr wins; if none, wrap around and
   // take the lowest-indexed requester. Equivalent to scanning rr_ptr+1,
   // rr_ptr+2, ... modulo NUM_CLUSTERS.
   always_comb begin
      w_found  = 1'b0;
      w_gnt    = '0;
      w_gnt_oh = '0;
      w_sum    = '0;
      w_cnt_op = '0;
      for (int i = 0; i < NUM_CLUSTERS; i++) begin
         if (!w_found && io_bus.req[i] && (ID_W'(i) > r_rr_ptr)) begin
            w_found     = 1'b1;
            w_gnt       = ID_W'(i);
            w_gnt_oh    = '0;
            w_gnt_oh[i] = 1'b1;
            w_sum       = io_bus.sum_bus[20*i +: 20];
            w_cnt_op    = io_bus.count_bus[12*i +: 12];
         end
      end
      for (int i = 0; i < NUM_CLUSTERS; i++) begin
         if (!w_found && io_bus.req[i]) begin
            w_found     = 1'b1;
            w_gnt       = ID_W'(i);
            w_gnt_oh    = '0;
            w_gnt_oh[i] = 1'b1;
            w_sum       = io_bus.sum_bus[20*i +: 20];
            w_cnt_op    = io_bus.count_bus[12*i +: 12];
         end
      end
   end

   // next-state / next-output logic
   always_comb begin
      w_state_nxt     = r_state;
      w_ack_nxt       = '0;
      w_res_valid_nxt = 1'b0;
      w_res_id_nxt    = r_res_id;
      w_res_q_nxt     = r_res_q;
      w_busy_nxt      = r_busy;
      w_div_ce_nxt    = r_div_ce;
      w_dividend_nxt  = r_dividend;
      w_divisor_nxt   = r_divisor;
      w_cnt_nxt       = r_cnt;
      w_rr_ptr_nxt    = r_rr_ptr;
      unique case (r_state)
         IDLE: begin
            // an outstanding ack blocks arbitration so a requester that is
            // still dropping req is not granted twice
            if (w_found && (r_ack == '0)) begin
               w_rr_ptr_nxt = w_gnt;
               w_ack_nxt    = w_gnt_oh;
               w_res_id_nxt = w_gnt;
               if (w_cnt_op == '0) begin
                  w_res_q_nxt     = '0;
                  w_res_valid_nxt = 1'b1;
               end else begin
                  w_dividend_nxt = w_sum;
                  w_divisor_nxt  = w_cnt_op;
                  w_div_ce_nxt   = 1'b1;
                  w_busy_nxt     = 1'b1;
                  w_cnt_nxt      = CNT_LOAD;
                  w_state_nxt    = BUSY;
               end
            end
         end
         BUSY: begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_res_q_nxt     = io_bus.div_quotient;
               w_res_valid_nxt = 1'b1;
               w_div_ce_nxt    = 1'b0;
               w_busy_nxt      = 1'b0;
               w_state_nxt     = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_ack       <= '0;
         r_res_valid <= 1'b0;
         r_res_id    <= '0;
         r_res_q     <= '0;
         r_busy      <= 1'b0;
         r_div_ce    <= 1'b0;
         r_div_sclr  <= 1'b1;  // clears any job left in the divider pipe
         r_dividend  <= '0;
         r_divisor   <= '0;
         r_cnt       <= '0;
         r_rr_ptr    <= ID_W'(NUM_CLUSTERS - 1);  // cluster 0 first
      end else begin
         r_state     <= w_state_nxt;
         r_ack       <= w_ack_nxt;
         r_res_valid <= w_res_valid_nxt;
         r_res_id    <= w_res_id_nxt;
         r_res_q     <= w_res_q_nxt;
         r_busy      <= w_busy_nxt;
         r_div_ce    <= w_div_ce_nxt;
         r_div_sclr  <= 1'b0;
         r_dividend  <= w_dividend_nxt;
         r_divisor   <= w_divisor_nxt;
         r_cnt       <= w_cnt_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
      end
   end

   assign io_bus.ack          = r_ack;
   assign io_bus.res_valid    = r_res_valid;
   assign io_bus.res_id       = r_res_id;
   assign io_bus.res_quotient = r_res_q;
   assign io_bus.busy         = r_busy;
   assign io_bus.div_ce       = r_div_ce;
   assign io_bus.div_sclr     = r_div_sclr;
   assign io_bus.div_dividend = r_dividend;
   assign io_bus.div_divisor  = r_divisor;

endmodule
